// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the BRAM port controller
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_src_t;

    // Illegal size or an address not aligned to the access size
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] a_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = a_lo[0];
            SZ_W:    bad = (a_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - sign/zero extension of BRAM read data by access size
module load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Extend the low byte or half; words pass through untouched
    always_comb begin
        ext = raw;
        case (size)
            SZ_B:    ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
            SZ_H:    ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - fetch/data arbiter and sequencer for BRAM port A
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_b,
    output logic              mem_h,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    state_t            state;
    gnt_src_t          last_gnt;
    gnt_src_t          lat_src;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_uns;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic              pick_d;
    logic              if_bad;
    logic              d_bad;
    logic              in_access;
    logic [31:0]       ld_ext;

    // Data wins when alone, under fixed priority, or when fetch was granted last
    always_comb begin
        pick_d    = d_req & (~if_req | (FIXED_PRIO != 0) | (last_gnt == GNT_IF));
        if_gnt    = (state == ST_IDLE) & if_req & ~pick_d;
        d_gnt     = (state == ST_IDLE) & pick_d;
        if_bad    = (if_addr[1:0] != 2'b00);
        d_bad     = access_bad(d_size, d_addr[1:0]);
    end

    // Port A is only driven during ACCESS so reset silences it at once
    always_comb begin
        in_access = (state == ST_ACCESS);
        mem_addr  = in_access ? lat_addr : '0;
        mem_wen   = in_access & lat_we;
        mem_b     = in_access & (lat_size == SZ_B);
        mem_h     = in_access & (lat_size == SZ_H);
        mem_din   = (in_access & lat_we) ? lat_wdata : 32'h0;
    end

    load_ext u_load_ext (
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .raw         (mem_dout),
        .ext         (ld_ext)
    );

    // Sequencer: grant and latch in IDLE, drive BRAM in ACCESS, capture read data in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            last_gnt  <= GNT_D;
            lat_src   <= GNT_IF;
            lat_we    <= 1'b0;
            lat_size  <= SZ_W;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'h0;
            d_err     <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_gnt) begin
                        last_gnt <= GNT_IF;
                        if (if_bad) begin
                            if_rvalid <= 1'b1;
                            if_err    <= 1'b1;
                            if_rdata  <= 32'h0;
                        end else begin
                            lat_src   <= GNT_IF;
                            lat_we    <= 1'b0;
                            lat_size  <= SZ_W;
                            lat_uns   <= 1'b0;
                            lat_addr  <= if_addr;
                            lat_wdata <= 32'h0;
                            state     <= ST_ACCESS;
                        end
                    end else if (d_gnt) begin
                        last_gnt <= GNT_D;
                        if (d_bad) begin
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                            d_rdata  <= 32'h0;
                        end else begin
                            lat_src   <= GNT_D;
                            lat_we    <= d_we;
                            lat_size  <= d_size;
                            lat_uns   <= d_unsigned;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (lat_we) begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= 32'h0;
                        state    <= ST_IDLE;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (lat_src == GNT_IF) begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_dout;
                    end else begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= ld_ext;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - randomized self-checking bench for mem_port_ctrl
module tb_mem_port_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [1:0]    d_size = 2'b00;
    logic          d_unsigned = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = 32'h0;
    logic          fp_if_req = 1'b0;
    logic          fp_d_req = 1'b0;

    logic          if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0]   if_rdata, d_rdata, mem_din;
    logic [AW-1:0] mem_addr;
    logic          mem_wen, mem_b, mem_h;
    logic [31:0]   mem_dout = 32'h0;

    logic          fp_if_gnt, fp_if_rvalid, fp_if_err, fp_d_gnt, fp_d_rvalid, fp_d_err;
    logic [31:0]   fp_if_rdata, fp_d_rdata, fp_mem_din;
    logic [AW-1:0] fp_mem_addr;
    logic          fp_mem_wen, fp_mem_b, fp_mem_h;
    logic [31:0]   fp_mem_dout;

    logic [7:0]    init_img [0:1023];
    logic [7:0]    bram     [0:1023];
    logic [7:0]    ref_mem  [0:1023];
    logic          bram_loaded = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    assign fp_mem_dout = 32'h0;

    mem_port_ctrl #(.ADDR_W(AW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_b(mem_b), .mem_h(mem_h),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    mem_port_ctrl #(.ADDR_W(AW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .if_req(fp_if_req), .if_addr(if_addr), .if_gnt(fp_if_gnt), .if_rvalid(fp_if_rvalid),
        .if_rdata(fp_if_rdata), .if_err(fp_if_err),
        .d_req(fp_d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid),
        .d_rdata(fp_d_rdata), .d_err(fp_d_err),
        .mem_addr(fp_mem_addr), .mem_wen(fp_mem_wen), .mem_b(fp_mem_b), .mem_h(fp_mem_h),
        .mem_din(fp_mem_din), .mem_dout(fp_mem_dout)
    );

    // Byte-addressed BRAM model: LSB-aligned write by ba/ha, registered word read
    always @(posedge clk) begin
        if (!bram_loaded) begin
            for (int i = 0; i < 1024; i++) bram[i] <= init_img[i];
            bram_loaded <= 1'b1;
        end else begin
            if (mem_wen) begin
                bram[mem_addr] <= mem_din[7:0];
                if (!mem_b) bram[mem_addr + 10'd1] <= mem_din[15:8];
                if (!mem_b && !mem_h) begin
                    bram[mem_addr + 10'd2] <= mem_din[23:16];
                    bram[mem_addr + 10'd3] <= mem_din[31:24];
                end
            end
            mem_dout <= {bram[mem_addr + 10'd3], bram[mem_addr + 10'd2],
                         bram[mem_addr + 10'd1], bram[mem_addr]};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input bit is_if, input logic [1:0] sz, input int a);
        if (is_if) return (a % 4) != 0;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns, input int a);
        int n;
        longint v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[(a + i) % 1024]) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One isolated transaction from a single requester, checked against the byte model
    task automatic xact(input bit is_if, input bit we, input logic [1:0] sz, input bit uns,
                        input int a, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd_o);
        bit          e, st;
        int          found, lat, nrv, nother, act, explat, n;
        logic [31:0] rd, expd, mask;
        logic        er;
        if (is_if) begin we = 1'b0; sz = 2'd2; end
        st = we && !is_if;
        e  = exp_err(is_if, sz, a);
        rd = 32'h0; er = 1'b0;
        @(posedge clk); #1;
        if (is_if) begin
            if_req = 1'b1; if_addr = AW'(a);
        end else begin
            d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns;
            d_addr = AW'(a); d_wdata = wd;
        end
        found = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (is_if ? if_gnt : d_gnt) begin found = i; break; end
        end
        chk({tag, "_gnt_wait"}, found, 0);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        lat = -1; nrv = 0; nother = 0; act = 0;
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (mem_wen || mem_b || mem_h || (mem_addr != '0)) act++;
            if (k == 1 && st && !e) begin
                chk({tag, "_wen"}, mem_wen, 1);
                chk({tag, "_maddr"}, mem_addr, a);
                chk({tag, "_bh"}, {mem_b, mem_h}, {sz == 2'd0, sz == 2'd1});
                chk({tag, "_din"}, mem_din & mask, wd & mask);
            end
            if (is_if ? if_rvalid : d_rvalid) begin
                nrv++;
                if (lat < 0) begin
                    lat = k;
                    rd  = is_if ? if_rdata : d_rdata;
                    er  = is_if ? if_err : d_err;
                end
            end
            if (is_if ? d_rvalid : if_rvalid) nother++;
        end
        explat = e ? 1 : st ? 2 : 3;
        expd   = (e || st) ? 32'h0 : exp_load(sz, uns, a);
        chk({tag, "_lat"}, lat, explat);
        chk({tag, "_pulses"}, nrv, 1);
        chk({tag, "_other"}, nother, 0);
        chk({tag, "_err"}, er, e);
        chk({tag, "_data"}, rd, expd);
        if (e) chk({tag, "_noaccess"}, act, 0);
        if (st && !e) begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) ref_mem[(a + i) % 1024] = 8'((wd >> (8 * i)) & 32'hFF);
        end
        rd_o = rd;
    endtask

    logic [31:0] rd;
    int          gq[$];
    int          fq[$];
    int          nrv;

    initial begin
        for (int i = 0; i < 1024; i++) init_img[i] = 8'($urandom);
        init_img[16] = 8'hEF; init_img[17] = 8'hBE; init_img[18] = 8'hAD; init_img[19] = 8'hDE;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_img[i];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {29'h0, if_gnt, if_rvalid, if_err} | {29'h0, d_gnt, d_rvalid, d_err}, 0);
        chk("rst_mem", {28'h0, mem_wen, mem_b, mem_h, 1'b0} | 32'(mem_addr), 0);
        chk("rst_data", if_rdata | d_rdata | mem_din, 0);
        @(posedge clk); #1 rst = 1'b1;

        xact(1, 0, 2'd2, 0, 'h010, 32'h0, "if_010", rd);
        chk("if_010_word", rd, 32'hDEADBEEF);
        xact(0, 1, 2'd0, 0, 'h021, 32'h1234_56A5, "st_b", rd);
        xact(0, 0, 2'd0, 0, 'h021, 32'h0, "ld_bs", rd);
        chk("ld_bs_val", rd, 32'hFFFF_FFA5);
        xact(0, 0, 2'd0, 1, 'h021, 32'h0, "ld_bu", rd);
        chk("ld_bu_val", rd, 32'h0000_00A5);
        xact(0, 1, 2'd1, 0, 'h040, 32'h0000_8001, "st_h", rd);
        xact(0, 0, 2'd1, 0, 'h040, 32'h0, "ld_hs", rd);
        chk("ld_hs_val", rd, 32'hFFFF_8001);
        xact(0, 0, 2'd1, 0, 'h003, 32'h0, "err_h", rd);
        xact(0, 0, 2'd2, 0, 'h002, 32'h0, "err_w", rd);
        xact(0, 0, 2'd3, 0, 'h044, 32'h0, "err_sz", rd);
        xact(0, 1, 2'd2, 0, 'h046, 32'hCAFE_F00D, "err_st", rd);
        xact(1, 0, 2'd2, 0, 'h012, 32'h0, "err_if", rd);
        xact(0, 1, 2'd2, 0, 'h3FC, 32'h89AB_CDEF, "st_top", rd);
        xact(0, 0, 2'd2, 0, 'h3FC, 32'h0, "ld_top", rd);
        chk("ld_top_val", rd, 32'h89AB_CDEF);

        for (int n = 0; n < 80; n++) begin
            bit          ri, rw, ru;
            logic [1:0]  rs;
            int          ra;
            ri = ($urandom % 4) == 0;
            rw = $urandom % 2;
            ru = $urandom % 2;
            rs = 2'($urandom % 4);
            ra = (($urandom % 4) == 0) ? int'($urandom_range(0, 1023)) : 'h200 + int'($urandom % 32);
            xact(ri, rw, rs, ru, ra, $urandom, "rnd", rd);
        end

        // Reset asserted while a store is in ACCESS: write must never reach BRAM
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_unsigned = 1'b0;
        d_addr = 10'h080; d_wdata = ~exp_load(2'd2, 1'b0, 'h080);
        @(negedge clk);
        chk("rst_st_gnt", d_gnt, 1);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        chk("rst_st_wen_pre", mem_wen, 1);
        #1 rst = 1'b0;
        #1 chk("rst_st_wen_drop", {mem_wen, 1'b0} | 2'(mem_addr != '0), 0);
        nrv = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_rvalid) nrv++;
        end
        chk("rst_st_no_rvalid", nrv, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Both requesters held continuously straight out of reset
        @(posedge clk); #1;
        if_addr = 10'h104; d_we = 1'b0; d_size = 2'd2; d_addr = 10'h100;
        if_req = 1'b1; d_req = 1'b1; fp_if_req = 1'b1; fp_d_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_gnt) gq.push_back(0);
            if (d_gnt) gq.push_back(1);
            if (fp_if_gnt) fq.push_back(0);
            if (fp_d_gnt) fq.push_back(1);
            if (gq.size() >= 4 && fq.size() >= 4) break;
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; fp_if_req = 1'b0; fp_d_req = 1'b0;
        chk("rr_count", (gq.size() >= 4) ? 1 : 0, 1);
        chk("fp_count", (fq.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", (i < gq.size()) ? gq[i] : -1, i % 2);
            chk("fp_order", (i < fq.size()) ? fq[i] : -1, 1);
        end
        repeat (5) @(posedge clk);

        xact(0, 0, 2'd2, 0, 'h080, 32'h0, "post_rst_ld", rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
